// File: rtl/blk_fetch.sv
// -----------------------------------------------------------------------------
// blk_fetch
//
// Fetches one 16x16 current block and its 32x32 reference search window from
// external frame memory and loads them into the motion estimator's current
// block register file and search-window memory.
//
// The memory port allows one outstanding read at a time. A fetch runs in two
// phases:
//   - Current block: 32 reads, two 64-bit words per 16-pixel row. Each row is
//     written as one 128-bit cur_WE write.
//   - Search window: 128 reads, four words per row for 32 rows. Rows and
//     columns that fall outside the frame are clamped, which replicates the
//     frame edges at word granularity.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   start              one-cycle fetch request, accepted only when idle
//   blk_x, blk_y       block column / row index (latched on accepted start)
//   cur_base, ref_base current / reference frame word base addresses
//   mem_rd_*           single-outstanding read port (req/addr/gnt/valid/data)
//   cur_WE, cur_data_in                       current block row write
//   search_WE, search_addr_in, search_data_in search window word write
//   curfilled, srcfilled                      level "phase complete" flags
//   busy               fetch in progress
//   err                one-cycle pulse when a start has out-of-range indices
// -----------------------------------------------------------------------------
module blk_fetch #(
    parameter int FRAME_W = 352,
    parameter int FRAME_H = 288,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        blk_x,
    input  logic [6:0]        blk_y,
    input  logic [ADDR_W-1:0] cur_base,
    input  logic [ADDR_W-1:0] ref_base,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [63:0]       mem_rd_data,
    output logic              cur_WE,
    output logic [127:0]      cur_data_in,
    output logic              search_WE,
    output logic [6:0]        search_addr_in,
    output logic [63:0]       search_data_in,
    output logic              curfilled,
    output logic              srcfilled,
    output logic              busy,
    output logic              err
);

    localparam int PITCH   = FRAME_W / 8;
    localparam int MAX_DIM = (FRAME_W > FRAME_H) ? FRAME_W : FRAME_H;
    // Two spare bits above the pixel range: one for the sign of coordinates
    // that lie above/left of the frame, one of headroom.
    localparam int COORD_W = $clog2(MAX_DIM) + 2;

    localparam logic [6:0] BLKS_X = 7'(FRAME_W / 16);
    localparam logic [6:0] BLKS_Y = 7'(FRAME_H / 16);

    localparam logic signed [COORD_W-1:0] ROW_MAX = COORD_W'(FRAME_H - 1);
    localparam logic signed [COORD_W-1:0] COL_MAX = COORD_W'(PITCH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CUR_REQ,
        CUR_WAIT,
        SRC_REQ,
        SRC_WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [6:0]        word_cnt;
    logic [6:0]        bx_q;
    logic [6:0]        by_q;
    logic [ADDR_W-1:0] cur_base_q;
    logic [ADDR_W-1:0] ref_base_q;
    logic [63:0]       even_word;
    logic              cur_last;
    logic              start_ok;

    // Word address of read number idx within the current phase.
    // Current block: idx = row*2 + half. Search window: idx = row*4 + column,
    // with the frame row/word column clamped into the frame.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic              is_src,
        input logic [6:0]        idx,
        input logic [6:0]        bx,
        input logic [6:0]        by,
        input logic [ADDR_W-1:0] base
    );
        logic signed [COORD_W-1:0] bx_s;
        logic signed [COORD_W-1:0] by_s;
        logic signed [COORD_W-1:0] row;
        logic signed [COORD_W-1:0] col;
        bx_s = signed'(COORD_W'(bx));
        by_s = signed'(COORD_W'(by));
        if (is_src) begin
            row = (by_s <<< 4) - signed'(COORD_W'(8)) + signed'(COORD_W'(idx[6:2]));
            col = (bx_s <<< 1) - signed'(COORD_W'(1)) + signed'(COORD_W'(idx[1:0]));
            if (row[COORD_W-1])
                row = '0;
            else if (row > ROW_MAX)
                row = ROW_MAX;
            if (col[COORD_W-1])
                col = '0;
            else if (col > COL_MAX)
                col = COL_MAX;
        end else begin
            row = (by_s <<< 4) + signed'(COORD_W'(idx[4:1]));
            col = (bx_s <<< 1) + signed'(COORD_W'(idx[0]));
        end
        return base + ADDR_W'(unsigned'(row)) * ADDR_W'(PITCH) + ADDR_W'(unsigned'(col));
    endfunction

    // A start is only acted on when the block lies inside the frame.
    assign start_ok = (blk_x < BLKS_X) && (blk_y < BLKS_Y);

    // Fetch sequencer. All outputs are registered here. The read address for
    // the next word is computed when the FSM moves into a request state, so it
    // is stable for the whole time the request is held. cur_last marks the
    // final row write so curfilled can follow it one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            word_cnt       <= '0;
            bx_q           <= '0;
            by_q           <= '0;
            cur_base_q     <= '0;
            ref_base_q     <= '0;
            even_word      <= '0;
            cur_last       <= 1'b0;
            mem_rd_req     <= 1'b0;
            mem_rd_addr    <= '0;
            cur_WE         <= 1'b0;
            cur_data_in    <= '0;
            search_WE      <= 1'b0;
            search_addr_in <= '0;
            search_data_in <= '0;
            curfilled      <= 1'b0;
            srcfilled      <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            cur_WE    <= 1'b0;
            search_WE <= 1'b0;
            err       <= 1'b0;
            cur_last  <= 1'b0;
            if (cur_last)
                curfilled <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            bx_q        <= blk_x;
                            by_q        <= blk_y;
                            cur_base_q  <= cur_base;
                            ref_base_q  <= ref_base;
                            curfilled   <= 1'b0;
                            srcfilled   <= 1'b0;
                            busy        <= 1'b1;
                            word_cnt    <= '0;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= word_addr(1'b0, 7'd0, blk_x, blk_y, cur_base);
                            state       <= CUR_REQ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                CUR_REQ: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        state      <= CUR_WAIT;
                    end
                end

                CUR_WAIT: begin
                    if (mem_rd_valid) begin
                        if (!word_cnt[0]) begin
                            even_word <= mem_rd_data;
                        end else begin
                            cur_data_in <= {even_word, mem_rd_data};
                            cur_WE      <= 1'b1;
                        end
                        mem_rd_req <= 1'b1;
                        if (word_cnt == 7'd31) begin
                            cur_last    <= 1'b1;
                            word_cnt    <= '0;
                            mem_rd_addr <= word_addr(1'b1, 7'd0, bx_q, by_q, ref_base_q);
                            state       <= SRC_REQ;
                        end else begin
                            word_cnt    <= word_cnt + 7'd1;
                            mem_rd_addr <= word_addr(1'b0, word_cnt + 7'd1, bx_q, by_q, cur_base_q);
                            state       <= CUR_REQ;
                        end
                    end
                end

                SRC_REQ: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        state      <= SRC_WAIT;
                    end
                end

                SRC_WAIT: begin
                    if (mem_rd_valid) begin
                        search_WE      <= 1'b1;
                        search_addr_in <= word_cnt;
                        search_data_in <= mem_rd_data;
                        if (word_cnt == 7'd127) begin
                            word_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            word_cnt    <= word_cnt + 7'd1;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= word_addr(1'b1, word_cnt + 7'd1, bx_q, by_q, ref_base_q);
                            state       <= SRC_REQ;
                        end
                    end
                end

                // The last search write is on the strobe during this cycle,
                // so srcfilled and the drop of busy land together next cycle.
                DONE: begin
                    srcfilled <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blk_fetch.sv
// -----------------------------------------------------------------------------
// tb_blk_fetch
//
// Self-checking bench for blk_fetch. A memory responder with configurable
// grant/valid latency serves reads from a synthetic frame memory whose word
// content is a fixed function of its address. A monitor records every write
// and the cycle at which the status flags change. Expected rows and search
// words come from a pixel-coordinate model of the block and its window.
//
// Cycle numbering: cycle 0 is the cycle in which start is high; cycle n is
// the n-th cycle after it.
// -----------------------------------------------------------------------------
module tb_blk_fetch;

    localparam int FW = 352;
    localparam int FH = 288;
    localparam int AW = 20;
    localparam int P  = FW / 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [6:0]     blk_x;
    logic [6:0]     blk_y;
    logic [AW-1:0]  cur_base;
    logic [AW-1:0]  ref_base;
    logic           mem_rd_req;
    logic [AW-1:0]  mem_rd_addr;
    logic           mem_rd_gnt;
    logic           mem_rd_valid;
    logic [63:0]    mem_rd_data;
    logic           cur_WE;
    logic [127:0]   cur_data_in;
    logic           search_WE;
    logic [6:0]     search_addr_in;
    logic [63:0]    search_data_in;
    logic           curfilled;
    logic           srcfilled;
    logic           busy;
    logic           err;

    logic           resp_valid;
    logic [63:0]    resp_data;
    logic           stray_valid;
    logic [63:0]    stray_data;

    assign mem_rd_valid = resp_valid | stray_valid;
    assign mem_rd_data  = stray_valid ? stray_data : resp_data;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc = 0;
    int t0  = 0;

    int gd_min = 0;
    int gd_max = 0;
    int vd_min = 1;
    int vd_max = 1;

    logic [AW-1:0]  reads[$];
    int             unstable = 0;
    logic [127:0]   cur_got[$];
    logic [6:0]     saddr_got[$];
    logic [63:0]    sdata_got[$];
    int             cur_fill_cyc = -1;
    int             src_fill_cyc = -1;
    int             busy_low_cyc = -1;
    int             req_cyc      = -1;
    int             err_cnt      = 0;
    logic           busy_seen    = 1'b0;

    blk_fetch #(
        .FRAME_W(FW),
        .FRAME_H(FH),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .blk_x         (blk_x),
        .blk_y         (blk_y),
        .cur_base      (cur_base),
        .ref_base      (ref_base),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_gnt    (mem_rd_gnt),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .cur_WE        (cur_WE),
        .cur_data_in   (cur_data_in),
        .search_WE     (search_WE),
        .search_addr_in(search_addr_in),
        .search_data_in(search_data_in),
        .curfilled     (curfilled),
        .srcfilled     (srcfilled),
        .busy          (busy),
        .err           (err)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synthetic frame memory: every word is a distinct function of its address.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {a, 4'h5, ~a, 4'hA, a[15:0]};
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Row i of the current block: pixels x = bx*16 .. bx*16+15 of line by*16+i.
    function automatic logic [127:0] exp_cur_row(input int bx, input int by, input int cb, input int i);
        int y;
        int w;
        y = by * 16 + i;
        w = (bx * 16) / 8;
        return {mem_word(AW'(cb + y * P + w)), mem_word(AW'(cb + y * P + w + 1))};
    endfunction

    // Search word k: the window starts 8 pixels above/left of the block; the
    // window line and the 8-pixel group are pulled back inside the frame.
    function automatic logic [63:0] exp_src_word(input int bx, input int by, input int rb, input int k);
        int y;
        int x;
        int w;
        y = clampi(by * 16 - 8 + k / 4, 0, FH - 1);
        x = bx * 16 - 8 + 8 * (k % 4);
        w = clampi(x / 8, 0, P - 1);
        return mem_word(AW'(rb + y * P + w));
    endfunction

    function automatic logic [10:0] out_flags();
        return {mem_rd_req, |mem_rd_addr, cur_WE, |cur_data_in, search_WE,
                |search_addr_in, |search_data_in, curfilled, srcfilled, busy, err};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: grant after gd cycles, data gd..+vd cycles later.
    // While waiting for grant the request and address must not move.
    initial begin
        logic [AW-1:0] a;
        int gd;
        int vd;
        mem_rd_gnt = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        @(negedge clk);
        forever begin
            mem_rd_gnt = 1'b0;
            resp_valid = 1'b0;
            if (mem_rd_req === 1'b1) begin
                a  = mem_rd_addr;
                gd = $urandom_range(gd_max, gd_min);
                vd = $urandom_range(vd_max, vd_min);
                repeat (gd) begin
                    @(negedge clk);
                    if (mem_rd_req !== 1'b1 || mem_rd_addr !== a) unstable++;
                end
                mem_rd_gnt = 1'b1;
                reads.push_back(a);
                @(negedge clk);
                mem_rd_gnt = 1'b0;
                repeat (vd - 1) @(negedge clk);
                resp_valid = 1'b1;
                resp_data  = mem_word(a);
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
    end

    // Write and status monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (cur_WE) cur_got.push_back(cur_data_in);
            if (search_WE) begin
                saddr_got.push_back(search_addr_in);
                sdata_got.push_back(search_data_in);
            end
            if (err) err_cnt++;
            if (busy) busy_seen = 1'b1;
            if (cyc - t0 >= 1) begin
                if (curfilled && cur_fill_cyc < 0) cur_fill_cyc = cyc - t0;
                if (srcfilled && src_fill_cyc < 0) src_fill_cyc = cyc - t0;
                if (mem_rd_req && req_cyc < 0) req_cyc = cyc - t0;
                if (!busy && busy_low_cyc < 0 && cyc - t0 >= 2) busy_low_cyc = cyc - t0;
            end
        end
    end

    // Pulse start for one cycle with the given block; returns in cycle 1.
    task automatic applyStimulus(input int bx, input int by, input int cb, input int rb);
        @(negedge clk);
        cur_got.delete();
        saddr_got.delete();
        sdata_got.delete();
        reads.delete();
        unstable     = 0;
        err_cnt      = 0;
        busy_seen    = 1'b0;
        cur_fill_cyc = -1;
        src_fill_cyc = -1;
        busy_low_cyc = -1;
        req_cyc      = -1;
        t0       = cyc;
        blk_x    = 7'(bx);
        blk_y    = 7'(by);
        cur_base = AW'(cb);
        ref_base = AW'(rb);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput($sformatf("%s done_in_budget", tag), 128'(timed_out), 128'd0);
    endtask

    task automatic verify_fetch(input string tag, input int bx, input int by, input int cb, input int rb);
        checkOutput($sformatf("%s cur_write_count", tag), 128'(cur_got.size()), 128'd16);
        for (int i = 0; i < 16; i++)
            if (i < cur_got.size())
                checkOutput($sformatf("%s cur_row%0d", tag, i), cur_got[i], exp_cur_row(bx, by, cb, i));
        checkOutput($sformatf("%s search_write_count", tag), 128'(saddr_got.size()), 128'd128);
        for (int k = 0; k < 128; k++) begin
            if (k < saddr_got.size()) begin
                checkOutput($sformatf("%s search_addr%0d", tag, k), 128'(saddr_got[k]), 128'(k));
                checkOutput($sformatf("%s search_data%0d", tag, k), 128'(sdata_got[k]),
                            128'(exp_src_word(bx, by, rb, k)));
            end
        end
        checkOutput($sformatf("%s read_count", tag), 128'(reads.size()), 128'd160);
        checkOutput($sformatf("%s addr_stable", tag), 128'(unstable), 128'd0);
        checkOutput($sformatf("%s curfilled_level", tag), 128'(curfilled), 128'd1);
        checkOutput($sformatf("%s srcfilled_level", tag), 128'(srcfilled), 128'd1);
    endtask

    initial begin
        int cb;
        int rb;
        int bx;
        int by;
        reset       = 1'b0;
        start       = 1'b0;
        blk_x       = '0;
        blk_y       = '0;
        cur_base    = '0;
        ref_base    = '0;
        stray_valid = 1'b0;
        stray_data  = '0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_in_reset", 128'(out_flags()), 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs_after_release", 128'(out_flags()), 128'd0);

        $display("[TB] interior block, best-case memory");
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(5, 4, cb, rb);
        wait_idle("interior");
        checkOutput("interior req_cycle", 128'(req_cyc), 128'd1);
        checkOutput("interior busy_seen", 128'(busy_seen), 128'd1);
        checkOutput("interior curfilled_cycle", 128'(cur_fill_cyc), 128'd66);
        checkOutput("interior srcfilled_cycle", 128'(src_fill_cyc), 128'd322);
        checkOutput("interior busy_low_cycle", 128'(busy_low_cyc), 128'd322);
        if (cur_got.size() > 0)
            checkOutput("interior row0_direct", cur_got[0],
                        {mem_word(AW'(cb + 64 * 44 + 10)), mem_word(AW'(cb + 64 * 44 + 11))});
        if (sdata_got.size() > 0)
            checkOutput("interior search0_direct", 128'(sdata_got[0]), 128'(mem_word(AW'(rb + 56 * 44 + 9))));
        verify_fetch("interior", 5, 4, cb, rb);

        $display("[TB] top-left corner block");
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(0, 0, cb, rb);
        wait_idle("corner");
        if (sdata_got.size() == 128) begin
            checkOutput("corner addr0_eq_addr4", 128'(sdata_got[4]), 128'(sdata_got[0]));
            checkOutput("corner addr0_word", 128'(sdata_got[0]), 128'(mem_word(AW'(rb))));
            checkOutput("corner row8_col1", 128'(sdata_got[33]), 128'(mem_word(AW'(rb))));
        end
        verify_fetch("corner", 0, 0, cb, rb);

        $display("[TB] bottom-right block");
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(21, 17, cb, rb);
        wait_idle("bottom_right");
        if (sdata_got.size() == 128) begin
            checkOutput("bottom_right last_word", 128'(sdata_got[127]),
                        128'(mem_word(AW'(rb + 287 * 44 + 43))));
            checkOutput("bottom_right row24_col3", 128'(sdata_got[99]),
                        128'(mem_word(AW'(rb + 287 * 44 + 43))));
        end
        verify_fetch("bottom_right", 21, 17, cb, rb);

        $display("[TB] backpressure grant+3 valid+5");
        gd_min = 3; gd_max = 3; vd_min = 5; vd_max = 5;
        bx = int'($urandom_range(21, 0));
        by = int'($urandom_range(17, 0));
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(bx, by, cb, rb);
        wait_idle("backpressure");
        verify_fetch("backpressure", bx, by, cb, rb);

        $display("[TB] random blocks, random latency");
        gd_min = 0; gd_max = 2; vd_min = 1; vd_max = 3;
        for (int n = 0; n < 3; n++) begin
            bx = int'($urandom_range(21, 0));
            by = int'($urandom_range(17, 0));
            cb = int'($urandom_range(32'h3FFFF, 0));
            rb = int'($urandom_range(32'h3FFFF, 0));
            applyStimulus(bx, by, cb, rb);
            wait_idle($sformatf("random%0d", n));
            verify_fetch($sformatf("random%0d", n), bx, by, cb, rb);
        end

        $display("[TB] start while busy");
        gd_min = 0; gd_max = 0; vd_min = 1; vd_max = 1;
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(3, 2, cb, rb);
        repeat (39) @(negedge clk);
        blk_x = 7'd7;
        blk_y = 7'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        checkOutput("busy_start no_err", 128'(err_cnt), 128'd0);
        verify_fetch("busy_start", 3, 2, cb, rb);

        $display("[TB] out-of-range starts");
        err_cnt   = 0;
        busy_seen = 1'b0;
        blk_x = 7'd22;
        blk_y = 7'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("bad_x err_pulses", 128'(err_cnt), 128'd1);
        checkOutput("bad_x busy_seen", 128'(busy_seen), 128'd0);
        checkOutput("bad_x curfilled_kept", 128'(curfilled), 128'd1);
        err_cnt   = 0;
        busy_seen = 1'b0;
        blk_x = 7'd0;
        blk_y = 7'd18;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("bad_y err_pulses", 128'(err_cnt), 128'd1);
        checkOutput("bad_y busy_seen", 128'(busy_seen), 128'd0);

        $display("[TB] reset mid-fetch, stray valid, restart");
        cb = int'($urandom_range(32'h3FFFF, 0));
        rb = int'($urandom_range(32'h3FFFF, 0));
        applyStimulus(10, 8, cb, rb);
        repeat (99) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset outputs_immediate", 128'(out_flags()), 128'd0);
        @(negedge clk);
        checkOutput("midreset outputs_held", 128'(out_flags()), 128'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        stray_data  = {$urandom, $urandom};
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        @(negedge clk);
        checkOutput("stray_valid ignored", 128'(out_flags()), 128'd0);
        applyStimulus(10, 8, cb, rb);
        wait_idle("restart");
        if (reads.size() > 0)
            checkOutput("restart first_read", 128'(reads[0]), 128'(AW'(cb + 128 * 44 + 20)));
        verify_fetch("restart", 10, 8, cb, rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
